// File: rtl/squarewave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : squarewave_pkg
//  Description : Shared tile geometry, pattern width and pattern-load FSM
//                state type for the square-wave pixel generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package squarewave_pkg;

    localparam int TILE_W = 8;    // pixels per tile horizontally
    localparam int TILE_H = 64;   // rows in the waveform band
    localparam int PAT_W  = 16;   // tiles per repeat (pattern bits)

    // Pattern-load handshake states
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pat_state_t;

    // Rotate a pattern one position towards the MSB, wrapping the MSB to bit 0
    function automatic logic [PAT_W-1:0] rotl1(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], v[PAT_W-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sqw_pattern_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sqw_pattern_reg
//  Description : Double-buffered waveform pattern. A write lands in a shadow
//                register and is committed to the active pattern on the next
//                frame_tick, so the displayed pattern never changes mid-frame.
//                Optional scroll (macro SQW_SCROLL_EN): rotates the active
//                pattern left by one every SCROLL_DIV frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqw_pattern_reg
    import squarewave_pkg::*;
#(
    parameter int SCROLL_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             pattern_wr,
    input  logic [PAT_W-1:0] pattern_din,
    output logic             pattern_ready,
    output logic [PAT_W-1:0] pattern
);

    pat_state_t       state;
    pat_state_t       state_nxt;
    logic             load_shadow;
    logic             commit;
    logic [PAT_W-1:0] shadow;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode; a write is accepted only in IDLE, and
    // a frame_tick arriving with that write does not commit until the next one
    always_comb begin
        state_nxt     = state;
        pattern_ready = 1'b0;
        load_shadow   = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                pattern_ready = 1'b1;
                if (pattern_wr) begin
                    load_shadow = 1'b1;
                    state_nxt   = PENDING;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow capture of the incoming pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load_shadow) begin
            shadow <= pattern_din;
        end
    end

`ifdef SQW_SCROLL_EN
    localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

    logic [CNT_W-1:0] scroll_cnt;

    // Active pattern with frame-rate scroll; a commit wins over a rotate and
    // restarts the frame count so a fresh pattern is shown for a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern    <= '0;
            scroll_cnt <= '0;
        end else if (commit) begin
            pattern    <= shadow;
            scroll_cnt <= '0;
        end else if (frame_tick) begin
            if (scroll_cnt == CNT_LAST) begin
                scroll_cnt <= '0;
                pattern    <= rotl1(pattern);
            end else begin
                scroll_cnt <= scroll_cnt + 1'b1;
            end
        end
    end
`else
    // Active pattern, static between commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
        end else if (commit) begin
            pattern <= shadow;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/squarewave_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : squarewave_pixel_gen
//  Description : Draws a 16-tile repeating square wave in a 64-row screen band.
//                Each 8-pixel tile is looked up in an external tile ROM using
//                the current and previous pattern bits plus the band row, so
//                edges between levels can be drawn by the ROM. Two-cycle
//                pixel-to-rgb latency. Optional scroll via SQW_SCROLL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module squarewave_pixel_gen
    import squarewave_pkg::*;
#(
    parameter int          Y_TOP      = 208,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter int          SCROLL_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             frame_tick,
    input  logic             pattern_wr,
    input  logic [PAT_W-1:0] pattern_din,
    output logic             pattern_ready,
    output logic [7:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic [11:0]      rgb
);

    localparam int COL_W = $clog2(TILE_W);
    localparam int IDX_W = $clog2(PAT_W);
    localparam int ROW_W = $clog2(TILE_H);

    logic [PAT_W-1:0] pattern;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_prev;
    logic [9:0]       row_full;
    logic             in_band;
    logic [2:0]       unused_x;

    logic [COL_W-1:0] col_q;
    logic             in_band_q;
    logic             video_on_q;

    sqw_pattern_reg #(
        .SCROLL_DIV (SCROLL_DIV)
    ) u_pattern_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_tick    (frame_tick),
        .pattern_wr    (pattern_wr),
        .pattern_din   (pattern_din),
        .pattern_ready (pattern_ready),
        .pattern       (pattern)
    );

    // Tile index repeats every 128 pixels; the upper x bits select nothing
    assign idx      = pixel_x[COL_W +: IDX_W];
    assign idx_prev = idx - 1'b1;
    assign unused_x = pixel_x[9:COL_W+IDX_W];

    // Band row; wraps harmlessly outside the band since in_band masks it
    assign row_full = pixel_y - 10'(Y_TOP);

    assign in_band = video_on
                  && ({1'b0, pixel_y} >= 11'(Y_TOP))
                  && ({1'b0, pixel_y} <= 11'(Y_TOP + TILE_H - 1));

    assign rom_addr = {pattern[idx_prev], pattern[idx], row_full[ROW_W-1:0]};

    // Stage 1: carry pixel context alongside the ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            in_band_q  <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            col_q      <= pixel_x[COL_W-1:0];
            in_band_q  <= in_band;
            video_on_q <= video_on;
        end
    end

    // Stage 2: pick the pixel colour from the ROM row (MSB = leftmost pixel)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (!video_on_q) begin
            rgb <= '0;
        end else if (in_band_q && rom_data[3'(TILE_W - 1) - col_q]) begin
            rgb <= FG_RGB;
        end else begin
            rgb <= BG_RGB;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_squarewave_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_squarewave_pixel_gen
//  Description : Self-checking bench for squarewave_pixel_gen with a tile ROM
//                model and a frame-level reference model of the pattern.
//                Honours SQW_SCROLL_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_squarewave_pixel_gen;

    localparam int          Y_TOP = 208;
    localparam logic [11:0] FG    = 12'hF3C;
    localparam logic [11:0] BG    = 12'h0A5;
    localparam int          SDIV  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pattern_wr = 1'b0;
    logic [15:0] pattern_din = '0;
    logic        pattern_ready;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic [11:0] rgb;

    int n_total = 0;
    int n_bad   = 0;

    bit          rom_fixed = 1'b0;

    // reference model state
    logic [15:0] m_pat = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    int          m_cnt = 0;
    logic [11:0] e0 = '0, e1 = '0;
    bit          v0 = 1'b0, v1 = 1'b0;

    squarewave_pixel_gen #(
        .Y_TOP      (Y_TOP),
        .FG_RGB     (FG),
        .BG_RGB     (BG),
        .SCROLL_DIV (SDIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .video_on      (video_on),
        .frame_tick    (frame_tick),
        .pattern_wr    (pattern_wr),
        .pattern_din   (pattern_din),
        .pattern_ready (pattern_ready),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rgb           (rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        if (rom_fixed) return 8'b00001111;
        return (a * 8'd29) ^ {a[2:0], a[7:3]} ^ 8'h5C;
    endfunction

    // synchronous tile ROM: data one cycle after address
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: called and returns at a falling edge
    task automatic step(input int x, input int y, input bit von,
                        input bit tick, input bit wr, input logic [15:0] din);
        int          idx;
        int          row;
        logic [7:0]  a;
        logic [7:0]  d;
        bit          band;
        bit          committed;
        logic [11:0] e;
        if (v1) chk("rgb", {20'd0, rgb}, {20'd0, e1});
        chk("ready", {31'd0, pattern_ready}, {31'd0, !m_pending});
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        video_on    = von;
        frame_tick  = tick;
        pattern_wr  = wr;
        pattern_din = din;
        #1;
        idx = (x / 8) % 16;
        row = (y - Y_TOP) & 63;
        a = {m_pat[(idx + 15) % 16], m_pat[idx], 6'(row)};
        chk("rom_addr", {24'd0, rom_addr}, {24'd0, a});
        d = rom_fn(a);
        band = von && (y >= Y_TOP) && (y < Y_TOP + 64);
        if (!von)                     e = 12'h000;
        else if (band && d[7 - x % 8]) e = FG;
        else                          e = BG;
        e1 = e0; v1 = v0; e0 = e; v0 = 1'b1;
        committed = 1'b0;
        if (m_pending && tick) begin
            m_pat = m_shadow; m_pending = 1'b0; committed = 1'b1; m_cnt = 0;
        end else if (!m_pending && wr) begin
            m_shadow = din; m_pending = 1'b1;
        end
`ifdef SQW_SCROLL_EN
        if (tick && !committed) begin
            m_cnt++;
            if (m_cnt == SDIV) begin
                m_cnt = 0;
                m_pat = {m_pat[14:0], m_pat[15]};
            end
        end
`endif
        @(negedge clk);
    endtask

    // Read back the active pattern through the cur bit of rom_addr
    task automatic sweep(input string tag, input logic [15:0] want);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < 16; i++) begin
            step(i * 8, Y_TOP, 1'b1, 1'b0, 1'b0, 16'h0);
            got[i] = rom_addr[6];
        end
        chk(tag, {16'd0, got}, {16'd0, want});
    endtask

    task automatic do_reset();
        pixel_x = '0; pixel_y = 10'(Y_TOP); video_on = 1'b1;
        frame_tick = 1'b0; pattern_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rgb", {20'd0, rgb}, 32'd0);
        chk("rst_ready", {31'd0, pattern_ready}, 32'd1);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        m_pat = '0; m_shadow = '0; m_pending = 1'b0; m_cnt = 0;
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rgb_hold", {20'd0, rgb}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        do_reset();

        // first pixels after release, blanked
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("blank_rgb", {20'd0, rgb}, 32'd0);

        // commit 0001 and probe tile addressing incl. idx 0 wrap
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h0001);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(8, Y_TOP, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("addr_x8", {24'd0, rom_addr}, 32'h80);
        step(0, Y_TOP, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("addr_x0", {24'd0, rom_addr}, 32'h40);

        // fixed ROM row: column 4 lit, column 3 dark
        rom_fixed = 1'b1;
        step(4, Y_TOP, 1'b1, 1'b0, 1'b0, 16'h0);
        step(3, Y_TOP, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("fg_col4", {20'd0, rgb}, {20'd0, FG});
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("bg_col3", {20'd0, rgb}, {20'd0, BG});
        rom_fixed = 1'b0;

        // mid-frame write is deferred to frame_tick
        step(100, Y_TOP + 10, 1'b1, 1'b0, 1'b1, 16'hAAAA);
        chk("ready_pending", {31'd0, pattern_ready}, 32'd0);
        sweep("pat_before_tick", 16'h0001);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("ready_after", {31'd0, pattern_ready}, 32'd1);
        sweep("pat_aaaa", 16'hAAAA);

        // write coinciding with frame_tick commits only on the next tick
        step(0, 0, 1'b0, 1'b1, 1'b1, 16'h5A5A);
        sweep("pat_coincide_hold", 16'hAAAA);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        sweep("pat_5a5a", 16'h5A5A);

        // reset while pending discards the shadow
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h1234);
        do_reset();
        sweep("pat_after_rst", 16'h0000);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        sweep("pat_discarded", 16'h0000);

        // randomized traffic against the model
        for (int n = 0; n < 1200; n++) begin
            int x, y;
            bit von, tick, wr;
            x    = $urandom_range(0, 639);
            y    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524)
                                               : $urandom_range(Y_TOP - 8, Y_TOP + 72);
            von  = ($urandom_range(0, 7) != 0);
            tick = ($urandom_range(0, 19) == 0);
            wr   = ($urandom_range(0, 9) == 0);
            step(x, y, von, tick, wr, 16'($urandom));
        end

        // scroll: 8001 rotates only on the 4th tick after commit
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(0, 0, 1'b0, 1'b0, 1'b1, 16'h8001);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        repeat (3) step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        sweep("scroll_3ticks", 16'h8001);
        step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0);
`ifdef SQW_SCROLL_EN
        sweep("scroll_4ticks", 16'h0003);
`else
        sweep("scroll_4ticks", 16'h8001);
`endif
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/squarewave_pixel_gen.md
SQUAREWAVE_PIXEL_GEN -- requirements
Module: squarewave_pixel_gen

Interface
REQ-001 SHALL have parameter Y_TOP, 208, first screen row of the 64-row waveform band.
REQ-002 SHALL have parameter FG_RGB, 12'hFFF, colour of waveform pixels.
REQ-003 SHALL have parameter BG_RGB, 12'h000, colour of all other visible pixels.
REQ-004 SHALL have parameter SCROLL_DIV, 4, frames per one-bit scroll step (used only when SQW_SCROLL_EN is defined).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, as already decided.
REQ-006 SHALL have port clk, input, 1, pixel clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports pixel_x and pixel_y, input, 10 each, current pixel coordinates from VGA sync.
REQ-009 SHALL have port video_on, input, 1, high while the pixel is in the visible area.
REQ-010 SHALL have port frame_tick, input, 1, one-cycle pulse at start of each vertical blank.
REQ-011 SHALL have ports pattern_wr (input, 1), pattern_din (input, 16) and pattern_ready (output, 1), the pattern-load handshake.
REQ-012 SHALL have port rom_addr, output, 8, {prev_bit, cur_bit, row[5:0]} to the tile ROM.
REQ-013 SHALL have port rom_data, input, 8, ROM row, valid one cycle after rom_addr; MSB is the leftmost pixel.
REQ-014 SHALL have port rgb, output, 12, pixel colour.

Function
REQ-015 SHALL split the screen into 8-pixel tiles: idx = pixel_x[6:3], a 0..15 index repeating every 128 pixels.
REQ-016 SHALL drive rom_addr combinationally from the active pattern: cur = pat[idx]; prev = pat[(idx-1) mod 16], so prev = pat[15] when idx = 0.
REQ-017 SHALL set row = (pixel_y - Y_TOP)[5:0].
REQ-018 SHALL set in_band when video_on = 1 and Y_TOP <= pixel_y <= Y_TOP+63.
REQ-019 SHALL, in stage 1, register pixel_x[2:0], in_band and video_on, aligned with rom_data.
REQ-020 SHALL, in stage 2, register rgb as follows: FG_RGB when in_band_q = 1 and rom_data[7 - col_q] = 1; BG_RGB when video_on_q = 1 otherwise; 12'h000 when video_on_q = 0.
REQ-021 SHALL give rgb a latency of exactly 2 cycles from the pixel inputs.
REQ-022 SHALL hold the 16-bit active pattern plus a shadow register, controlled by FSM states IDLE and PENDING.
REQ-023 SHALL behave as follows in IDLE: pattern_ready = 1; pattern_wr = 1 loads the shadow from pattern_din and moves to PENDING.
REQ-024 SHALL behave as follows in PENDING: pattern_ready = 0 and pattern_wr is ignored; on frame_tick the shadow is copied to the active pattern and the FSM returns to IDLE.
REQ-025 SHALL, when pattern_wr and frame_tick coincide in IDLE, capture to the shadow only; the commit happens at the next frame_tick, never in the same cycle.
REQ-026 SHALL change the active pattern only on frame_tick, so there is no mid-frame tearing.

Reset
REQ-027 SHALL, while rst_n = 0, force: rgb = 0, FSM = IDLE, pattern_ready = 1, active pattern = 16'h0000, shadow = 0, pipeline registers = 0, scroll counter = 0.
REQ-028 SHALL, on reset asserted mid-frame or in PENDING, discard any pending pattern; the first valid rgb follows 2 cycles after release.

Configuration
REQ-029 SHALL, with SQW_SCROLL_EN defined, use a frame counter 0..SCROLL_DIV-1 that increments on each frame_tick.
REQ-030 SHALL, with SQW_SCROLL_EN defined, rotate the active pattern left by 1 on the frame_tick where the counter wraps.
REQ-031 SHALL give a commit precedence over a rotate in the same cycle, and reset the counter to 0 on commit.
REQ-032 SHALL, without SQW_SCROLL_EN, remove the counter and rotate logic; the pattern is static between commits.

Structure
REQ-033 SHALL place TILE_W = 8, TILE_H = 64, PAT_W = 16 and the IDLE/PENDING state typedef in shared package squarewave_pkg.
REQ-034 SHALL implement the shadow register, FSM and scroll logic as sub-module sqw_pattern_reg; the pixel pipeline stays in the top level.

Verification
REQ-035 SHALL be verified by: reset release, then pixel (0,0) with video_on = 0 -> rgb = 0 at +2 cycles.
REQ-036 SHALL be verified by: committed pattern 16'h0001, pixel_x = 8, pixel_y = Y_TOP -> rom_addr = {1,0,6'd0}; pixel_x = 0 -> rom_addr = {0,1,6'd0} (wraps to pat[15] = 0).
REQ-037 SHALL be verified by: ROM model returning 8'b00001111, col 4 in band -> rgb = FG_RGB; col 3 -> BG_RGB.
REQ-038 SHALL be verified by: pattern_wr with 16'hAAAA mid-frame -> pattern_ready = 0, active pattern unchanged until frame_tick, then 16'hAAAA and pattern_ready = 1.
REQ-039 SHALL be verified by: pattern_wr coinciding with frame_tick -> commit only at the following frame_tick.
REQ-040 SHALL be verified by (SQW_SCROLL_EN, SCROLL_DIV = 4): pattern 16'h8001 -> 16'h0003 after the 4th frame_tick.
